kernel_bc_dataflow_start_ctrl: RTL and testbench
================================================

# kernel_bc_dataflow_start_ctrl

Top-level start sequencer for the kernel_bc dataflow region. It converts the host-side ap_start/ap_ready/ap_done/ap_continue handshake into one start token per iteration for each of NUM_PROC per-process start FIFOs (the start_for_* FIFOs). It retires iterations on the sink process's done pulse and caps the number of iterations in flight.

## Interface
- NUM_PROC, 3: number of downstream start FIFOs fed per iteration (≥1).
- MAX_INFLIGHT, 4: maximum iterations issued but not yet acknowledged by ap_continue (≥1).
- CNT_W, $clog2(MAX_INFLIGHT+1): width of the in-flight and done counters (derived; not overridden).
- clk  in  1  sole clock; all logic on the rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- ap_start  in  1  host request to launch an iteration; held until ap_ready.
- ap_ready  out  1  one-cycle pulse: the iteration's tokens are all written.
- ap_done  out  1  high while at least one retired iteration is unacknowledged.
- ap_continue  in  1  host acknowledge; consumes one done when sampled with ap_done.
- ap_idle  out  1  no iteration pending, issuing or in flight.
- start_full_n  in  NUM_PROC  per-FIFO not-full.
- start_write  out  NUM_PROC  per-FIFO write strobe; token data is constant 1.
- proc_done  in  1  one-cycle pulse from the sink process; retires one iteration.
- iter_count  out  32  number of iterations fully issued; wraps modulo 2^32.
- err_spurious_done  out  1  sticky flag; cleared only by reset.

## Operation
- FSM states IDLE and ISSUE. Register pend_mask[NUM_PROC].
- IDLE: if ap_start && inflight < MAX_INFLIGHT, then load pend_mask to all ones and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: start_write[i] = pend_mask[i] & start_full_n[i]. Each written bit clears in pend_mask. Each FIFO receives exactly one token per iteration, regardless of the order in which FIFOs become non-full.
- Issue completion is the cycle in which all remaining pend bits are written. In that cycle: ap_ready=1, inflight+1, iter_count+1, next state IDLE.
- inflight counts iterations that have completed issue but are not yet acknowledged. It decrements on ap_done && ap_continue.
- done_cnt increments on a valid proc_done and decrements on ap_done && ap_continue. ap_done = (done_cnt != 0).
- proc_done is valid only if inflight > done_cnt. Otherwise it is ignored and err_spurious_done is set.
- Simultaneous increment and decrement of either counter leaves the value unchanged.
- ap_idle = (state==IDLE) && (inflight==0).
- No start_write is asserted outside ISSUE.

## Timing
- Reset values (reset_n=0 at an edge): state=IDLE, pend_mask=0, inflight=0, done_cnt=0, iter_count=0, err_spurious_done=0. Outputs: ap_ready=0, ap_done=0, start_write=0, ap_idle=1.
- Minimum issue latency: ap_start is sampled in IDLE at cycle N. With all FIFOs non-full, start_write is all ones and ap_ready=1 at cycle N+1.
- Peak throughput is one iteration per 2 cycles (ISSUE followed by IDLE).
- Back-pressure: ISSUE persists while any pend bit's FIFO is full. ap_ready waits for the last FIFO.
- Cap: at inflight==MAX_INFLIGHT, ap_start is ignored until an ap_continue acknowledge. An acknowledge in cycle N allows acceptance in cycle N+1.
- ap_ready and ap_done are registered-state decodes, with no combinational path from ap_start or ap_continue. start_write depends combinationally on start_full_n.
- A reset asserted mid-ISSUE abandons the partial iteration. Tokens already written are not retracted; the system resets together.

## Structure
- Shared package kernel_bc_ctrl_pkg holds the FSM state enum (IDLE, ISSUE) and the token-data constant.
- Sub-module kernel_bc_updown_cnt (parameter W; ports inc, dec, q, reset, clk) is instantiated for inflight and for done_cnt.
- Everything else is inline: pend_mask, the FSM and iter_count.

## Test plan
- Free run, NUM_PROC=3, FIFOs never full, ap_start held, ap_continue=1, proc_done pulsed 3 cycles after each ap_ready → one ap_ready every 2 cycles; each start_write bit pulses once per iteration; iter_count=10 after 10 ready pulses.
- Skewed back-pressure: start_full_n[1]=0 for 5 cycles and then 1 → bits 0 and 2 write in the first ISSUE cycle; bit 1 writes 5 cycles later, together with ap_ready; no duplicate writes.
- Cap, MAX_INFLIGHT=4, ap_continue=0 → exactly 4 ap_ready pulses, then none. Then 1 proc_done plus 1 ap_continue → a 5th ap_ready follows.
- Done and continue collide: proc_done in the same cycle as ap_done && ap_continue with done_cnt=1 → done_cnt stays 1 and ap_done stays high.
- Spurious done: proc_done with inflight=0 → err_spurious_done=1 and stays set; done_cnt stays 0.
- Reset during ISSUE with pend_mask=3'b010 → the next cycle has start_write=0, ap_idle=1 and all counters 0.

Source files
------------

// File: rtl/kernel_bc_ctrl_pkg.sv
// ============================================================================
// Module   : kernel_bc_ctrl_pkg
// Brief    : Shared types and constants for the kernel_bc start sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package kernel_bc_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Payload written into every start_for_* FIFO.
    localparam logic START_TOKEN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/kernel_bc_updown_cnt.sv
// ============================================================================
// Module   : kernel_bc_updown_cnt
// Brief    : Up/down counter; simultaneous inc and dec cancel out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module kernel_bc_updown_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && !dec) begin
            q_d = q_q + W'(1);
        end else if (dec && !inc) begin
            q_d = q_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/kernel_bc_dataflow_start_ctrl.sv
// ============================================================================
// Module   : kernel_bc_dataflow_start_ctrl
// Brief    : Turns the ap_* host handshake into one start token per process
//            FIFO per iteration, retiring iterations on proc_done.
// Revision : 1.0
// ============================================================================
`default_nettype none

module kernel_bc_dataflow_start_ctrl
    import kernel_bc_ctrl_pkg::*;
#(
    parameter int NUM_PROC     = 3,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ap_start,
    output logic                ap_ready,
    output logic                ap_done,
    input  logic                ap_continue,
    output logic                ap_idle,
    input  logic [NUM_PROC-1:0] start_full_n,
    output logic [NUM_PROC-1:0] start_write,
    input  logic                proc_done,
    output logic [31:0]         iter_count,
    output logic                err_spurious_done
);

    localparam int              CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CAP  = CNT_W'(MAX_INFLIGHT);

    state_e              state_q, state_d;
    logic [NUM_PROC-1:0] pend_mask_q, pend_mask_d;
    logic [31:0]         iter_count_q, iter_count_d;
    logic                err_spurious_done_q, err_spurious_done_d;

    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    done_cnt;
    logic                can_accept;
    logic                ack;
    logic                done_valid;

    assign can_accept = ap_start && (inflight < CAP);
    assign ack        = ap_done && ap_continue;
    // A done pulse is only meaningful if some issued iteration has not yet retired.
    assign done_valid = proc_done && (inflight > done_cnt);

    kernel_bc_updown_cnt #(
        .W (CNT_W)
    ) u_inflight_cnt (
        .clk   (clk),
        .reset (!reset_n),
        .inc   (ap_ready),
        .dec   (ack),
        .q     (inflight)
    );

    kernel_bc_updown_cnt #(
        .W (CNT_W)
    ) u_done_cnt (
        .clk   (clk),
        .reset (!reset_n),
        .inc   (done_valid),
        .dec   (ack),
        .q     (done_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q             <= IDLE;
            pend_mask_q         <= '0;
            iter_count_q        <= '0;
            err_spurious_done_q <= 1'b0;
        end else begin
            state_q             <= state_d;
            pend_mask_q         <= pend_mask_d;
            iter_count_q        <= iter_count_d;
            err_spurious_done_q <= err_spurious_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_mask_d = pend_mask_q;
        case (state_q)
            IDLE: begin
                if (can_accept) begin
                    state_d     = ISSUE;
                    pend_mask_d = '1;
                end
            end
            ISSUE: begin
                // Written bits retire so a FIFO that drains late still gets only one token.
                pend_mask_d = pend_mask_q & ~start_write;
                if (ap_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                pend_mask_d = '0;
            end
        endcase
    end

    always_comb begin
        start_write = '0;
        ap_ready    = 1'b0;
        if (state_q == ISSUE) begin
            start_write = pend_mask_q & start_full_n & {NUM_PROC{START_TOKEN}};
            ap_ready    = ((pend_mask_q & ~start_full_n) == '0);
        end
    end

    always_comb begin
        iter_count_d        = ap_ready ? (iter_count_q + 32'd1) : iter_count_q;
        err_spurious_done_d = err_spurious_done_q | (proc_done && !done_valid);
    end

    assign ap_done           = (done_cnt != '0);
    assign ap_idle           = (state_q == IDLE) && (inflight == '0);
    assign iter_count        = iter_count_q;
    assign err_spurious_done = err_spurious_done_q;

endmodule

`default_nettype wire

// File: tb/tb_kernel_bc_dataflow_start_ctrl.sv
// ============================================================================
// Module   : tb_kernel_bc_dataflow_start_ctrl
// Brief    : Directed bench with an ap_ready scoreboard for the start sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_kernel_bc_dataflow_start_ctrl;

    localparam int NP = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_continue = 1'b0;
    logic          man_pd = 1'b0;
    logic          auto_pd = 1'b0;
    logic          auto_en = 1'b0;
    logic          proc_done;
    logic [NP-1:0] start_full_n = '1;
    logic          ap_ready, ap_done, ap_idle, err_spurious_done;
    logic [NP-1:0] start_write;
    logic [31:0]   iter_count;

    int            checks = 0;
    int            errors = 0;
    int unsigned   exp_q[$];

    assign proc_done = man_pd | auto_pd;

    kernel_bc_dataflow_start_ctrl #(
        .NUM_PROC     (NP),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ap_start          (ap_start),
        .ap_ready          (ap_ready),
        .ap_done           (ap_done),
        .ap_continue       (ap_continue),
        .ap_idle           (ap_idle),
        .start_full_n      (start_full_n),
        .start_write       (start_write),
        .proc_done         (proc_done),
        .iter_count        (iter_count),
        .err_spurious_done (err_spurious_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(ap_idle && !ap_done) && k < 40);
        chk(name, {30'd0, ap_idle, ap_done}, 32'h2);
    endtask

    // Sink model: proc_done pulses three cycles after each ap_ready when enabled.
    initial begin
        logic [2:0] pipe = '0;
        forever begin
            @(negedge clk);
            pipe = {pipe[1:0], auto_en && reset_n && ap_ready};
            @(posedge clk);
            #1;
            auto_pd = pipe[2];
        end
    end

    // Scoreboard monitor: each ap_ready retires one expected iteration.
    initial begin
        logic [NP-1:0] acc = '0;
        int unsigned   e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                acc = '0;
            end else begin
                if (|start_write) chk("no_dup_write", 32'(start_write & acc), 32'd0);
                acc = acc | start_write;
                if (ap_ready) begin
                    chk("ready_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("ready_iter_count", iter_count, e);
                    end
                    chk("iter_all_tokens", 32'(acc), 32'(3'b111));
                    acc = '0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrdy;
        int last;
        int t;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_ap_ready", 32'(ap_ready), 32'd0);
        chk("rst_ap_done", 32'(ap_done), 32'd0);
        chk("rst_start_write", 32'(start_write), 32'd0);
        chk("rst_ap_idle", 32'(ap_idle), 32'd1);
        chk("rst_iter_count", iter_count, 32'd0);
        chk("rst_err", 32'(err_spurious_done), 32'd0);
        step();
        reset_n = 1'b1;

        // Free run: ten iterations, one every two cycles
        step();
        ap_continue = 1'b1;
        auto_en     = 1'b1;
        ap_start    = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(i);
        nrdy = 0; last = 0; t = 0;
        while (nrdy < 10 && t < 60) begin
            @(negedge clk);
            t++;
            if (ap_ready) begin
                if (nrdy == 0) chk("first_ready_latency", t, 2);
                else           chk("ready_spacing", t - last, 2);
                last = t;
                nrdy++;
                if (nrdy == 10) ap_start = 1'b0;
            end
        end
        chk("free_ready_count", nrdy, 10);
        @(negedge clk);
        chk("free_iter_count", iter_count, 32'd10);
        wait_idle("free_drain_idle");

        // Skewed back-pressure on FIFO 1
        step();
        start_full_n = 3'b101;
        ap_start     = 1'b1;
        exp_q.push_back(10);
        @(negedge clk);
        chk("skew_idle_no_write", 32'({ap_ready, start_write}), 32'h0);
        step();
        ap_start = 1'b0;
        @(negedge clk);
        chk("skew_first_write", 32'({ap_ready, start_write}), 32'h5);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("skew_hold", 32'({ap_ready, start_write}), 32'h0);
        end
        step();
        start_full_n = 3'b111;
        @(negedge clk);
        chk("skew_last_write", 32'({ap_ready, start_write}), 32'hA);
        wait_idle("skew_drain_idle");

        // In-flight cap
        step();
        auto_en     = 1'b0;
        ap_continue = 1'b0;
        ap_start    = 1'b1;
        for (int i = 11; i < 15; i++) exp_q.push_back(i);
        nrdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ap_ready) nrdy++;
        end
        chk("cap_ready_count", nrdy, 4);
        chk("cap_not_idle", 32'(ap_idle), 32'd0);
        step();
        man_pd = 1'b1;
        step();
        man_pd = 1'b0;
        @(negedge clk);
        chk("cap_done_up", 32'(ap_done), 32'd1);
        chk("cap_still_blocked", 32'(ap_ready), 32'd0);
        step();
        ap_continue = 1'b1;
        exp_q.push_back(15);
        step();
        ap_continue = 1'b0;
        @(negedge clk);
        chk("cap_resume_wait", 32'({ap_ready, ap_done}), 32'h0);
        step();
        @(negedge clk);
        chk("cap_resume_ready", 32'(ap_ready), 32'd1);
        ap_start = 1'b0;

        // proc_done collides with an acknowledge while done_cnt is 1
        step();
        man_pd = 1'b1;
        step();
        ap_continue = 1'b1;
        @(negedge clk);
        chk("collide_pre_done", 32'(ap_done), 32'd1);
        step();
        man_pd      = 1'b0;
        ap_continue = 1'b0;
        @(negedge clk);
        chk("collide_done_held", 32'(ap_done), 32'd1);
        step();
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        @(negedge clk);
        chk("collide_done_cleared", 32'(ap_done), 32'd0);
        step();
        ap_continue = 1'b1;
        man_pd      = 1'b1;
        step();
        man_pd = 1'b0;
        step();
        man_pd = 1'b1;
        step();
        man_pd = 1'b0;
        wait_idle("collide_drain_idle");
        step();
        ap_continue = 1'b0;

        // Spurious done with nothing in flight
        @(negedge clk);
        chk("spurious_err_clear", 32'(err_spurious_done), 32'd0);
        step();
        man_pd = 1'b1;
        step();
        man_pd = 1'b0;
        @(negedge clk);
        chk("spurious_err_set", 32'(err_spurious_done), 32'd1);
        chk("spurious_no_done", 32'(ap_done), 32'd0);
        repeat (3) step();
        @(negedge clk);
        chk("spurious_err_sticky", 32'(err_spurious_done), 32'd1);

        // Reset while FIFO 1 still pending
        step();
        start_full_n = 3'b101;
        ap_start     = 1'b1;
        step();
        ap_start = 1'b0;
        @(negedge clk);
        chk("rst_mid_partial_write", 32'(start_write), 32'h5);
        step();
        reset_n = 1'b0;
        step();
        start_full_n = 3'b111;
        @(negedge clk);
        chk("rst_mid_write", 32'(start_write), 32'd0);
        chk("rst_mid_ready", 32'(ap_ready), 32'd0);
        chk("rst_mid_idle", 32'(ap_idle), 32'd1);
        chk("rst_mid_done", 32'(ap_done), 32'd0);
        chk("rst_mid_iter", iter_count, 32'd0);
        chk("rst_mid_err", 32'(err_spurious_done), 32'd0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_quiet", 32'({ap_idle, start_write}), 32'h8);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
